clk_div_multi: RTL and testbench

- Parametrised multi-channel clock divider/strobe generator, clocked from the 100 MHz system clock.
- Each channel produces a 50 % square wave (clk_out) and a one-cycle tick on each rising edge of that wave.
- The half-period is reprogrammable at runtime through a write port. A new value takes effect glitch-free at the channel's next terminal count.
- Feeds DDS sample-rate strobes and slow display/LED timing.

---
 rtl/clk_div_multi_pkg.sv | 18 +
 rtl/clk_div_ch.sv | 92 +++++++++
 rtl/clk_div_multi.sv | 49 ++++
 tb/tb_clk_div_multi.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_multi_pkg.sv
// Shared constants and types for the multi-channel clock divider.
// Half-period constants assume the 100 MHz system clock.
package clk_div_multi_pkg;

  localparam int unsigned F_CLK      = 100_000_000;
  localparam int unsigned HALF_10KHZ = 4999;
  localparam int unsigned HALF_1KHZ  = 49_999;
  localparam int unsigned HALF_0P5HZ = 99_999_999;

  // Per-cycle channel action, in priority order: clear > hold > terminal > count.
  typedef enum logic [1:0] {
    EV_COUNT = 2'd0,
    EV_TERM  = 2'd1,
    EV_HOLD  = 2'd2,
    EV_CLEAR = 2'd3
  } ch_event_e;

endpackage

// File: rtl/clk_div_ch.sv
// Single divider channel: half-period counter, pending reload register,
// 50 % square-wave toggle and rising-edge tick.
module clk_div_ch
  import clk_div_multi_pkg::*;
#(
  parameter int unsigned       CNT_W     = 32,
  parameter logic [CNT_W-1:0]  HALF_INIT = '0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             sync_clr,
  input  logic             wr_en,
  input  logic [CNT_W-1:0] wr_data,
  output logic             clk_out,
  output logic             tick,
  output logic             pend
);

  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [CNT_W-1:0] half_q,  half_d;
  logic [CNT_W-1:0] pdata_q, pdata_d;
  logic             clk_q,   clk_d;
  logic             tick_q,  tick_d;
  logic             pend_q,  pend_d;
  logic             apply;
  ch_event_e        ev;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q   <= '0;
      half_q  <= HALF_INIT;
      pdata_q <= '0;
      clk_q   <= 1'b0;
      tick_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      half_q  <= half_d;
      pdata_q <= pdata_d;
      clk_q   <= clk_d;
      tick_q  <= tick_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    if (sync_clr)              ev = EV_CLEAR;
    else if (!en)              ev = EV_HOLD;
    else if (cnt_q >= half_q)  ev = EV_TERM;
    else                       ev = EV_COUNT;
  end

  always_comb begin
    cnt_d   = cnt_q;
    half_d  = half_q;
    pdata_d = pdata_q;
    clk_d   = clk_q;
    tick_d  = 1'b0;
    pend_d  = pend_q;
    apply   = 1'b0;
    case (ev)
      EV_CLEAR, EV_HOLD: begin
        cnt_d = '0;
        clk_d = 1'b0;
        apply = pend_q;
      end
      EV_TERM: begin
        cnt_d  = '0;
        clk_d  = ~clk_q;
        tick_d = ~clk_q;
        apply  = pend_q;
      end
      default: cnt_d = cnt_q + CNT_W'(1);
    endcase
    // Reload consumes the old pending value first, so a write landing in the
    // same cycle survives as the next pending value.
    if (apply) begin
      half_d = pdata_q;
      pend_d = 1'b0;
    end
    if (wr_en) begin
      pdata_d = wr_data;
      pend_d  = 1'b1;
    end
  end

  assign clk_out = clk_q;
  assign tick    = tick_q;
  assign pend    = pend_q;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel clock divider / strobe generator: NUM_CH independent
// channels sharing one write port and a global phase-realign pulse.
module clk_div_multi
  import clk_div_multi_pkg::*;
#(
  parameter int unsigned              NUM_CH   = 2,
  parameter int unsigned              CNT_W    = 32,
  parameter logic [NUM_CH*CNT_W-1:0]  DIV_INIT = {32'(HALF_0P5HZ), 32'(HALF_10KHZ)}
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [NUM_CH-1:0] en,
  input  logic              sync_clr,
  input  logic              wr_en,
  input  logic [3:0]        wr_ch,
  input  logic [CNT_W-1:0]  wr_data,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] pend
);

  logic [NUM_CH-1:0] wr_sel;

  // Out-of-range channel indices match no channel and are dropped.
  always_comb begin
    wr_sel = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      wr_sel[c] = wr_en && (32'(wr_ch) == c);
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    clk_div_ch #(
      .CNT_W     (CNT_W),
      .HALF_INIT (DIV_INIT[c*CNT_W +: CNT_W])
    ) u_ch (
      .clk      (clk),
      .rstn     (rstn),
      .en       (en[c]),
      .sync_clr (sync_clr),
      .wr_en    (wr_sel[c]),
      .wr_data  (wr_data),
      .clk_out  (clk_out[c]),
      .tick     (tick[c]),
      .pend     (pend[c])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi: ch0 at 10 kHz reset value, ch1 overridden
// to H=9; outputs sampled 1 ns after each rising clock edge.
module tb_clk_div_multi;

  logic        clk = 1'b0;
  logic        rstn;
  logic [1:0]  en;
  logic        sync_clr;
  logic        wr_en;
  logic [3:0]  wr_ch;
  logic [31:0] wr_data;
  logic [1:0]  clk_out;
  logic [1:0]  tick;
  logic [1:0]  pend;

  int errors = 0;
  int checks = 0;

  clk_div_multi #(
    .NUM_CH   (2),
    .CNT_W    (32),
    .DIV_INIT ({32'd9, 32'd4999})
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .en       (en),
    .sync_clr (sync_clr),
    .wr_en    (wr_en),
    .wr_ch    (wr_ch),
    .wr_data  (wr_data),
    .clk_out  (clk_out),
    .tick     (tick),
    .pend     (pend)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: got=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got=%0d required=%0d", tag, got, exp);
    end
  endtask

  // One clock; pulse inputs are single-cycle.
  task automatic step();
    @(posedge clk);
    #1;
    wr_en    = 1'b0;
    sync_clr = 1'b0;
  endtask

  task automatic wr(input logic [3:0] ch, input logic [31:0] data);
    wr_en   = 1'b1;
    wr_ch   = ch;
    wr_data = data;
  endtask

  // n cycles of ch0; bit k of each vector is the value expected at sample k.
  task automatic run0(input int n, input logic [31:0] ce, input logic [31:0] te,
                      input logic [31:0] pe, input string tag);
    for (int k = 0; k < n; k++) begin
      step();
      chk($sformatf("%s_clk%0d", tag, k),  32'(clk_out[0]), 32'(ce[k]));
      chk($sformatf("%s_tick%0d", tag, k), 32'(tick[0]),    32'(te[k]));
      chk($sformatf("%s_pend%0d", tag, k), 32'(pend[0]),    32'(pe[k]));
    end
  endtask

  initial begin
    int last0, last1, hi0, n0, w, f0, f1, s1;
    rstn = 1'b0; en = 2'b00; sync_clr = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_clk",  32'(clk_out), 32'd0);
    chk("rst_tick", 32'(tick),    32'd0);
    chk("rst_pend", 32'(pend),    32'd0);

    // Reset-default periods.
    rstn = 1'b1; en = 2'b11;
    last0 = 0; last1 = 0; hi0 = 0; n0 = 0;
    for (int i = 1; i <= 30000; i++) begin
      step();
      if (tick[0]) begin
        if (last0 == 0) chk("t1_first0", i, 5000);
        else            chk("t1_per0", i - last0, 10000);
        last0 = i; n0++;
      end
      if (tick[1]) begin
        if (last1 == 0) chk("t1_first1", i, 10);
        else            chk("t1_per1", i - last1, 20);
        last1 = i;
      end
      if (clk_out[0]) hi0++;
      else if (hi0 != 0) begin
        chk("t1_high0", hi0, 5000);
        hi0 = 0;
      end
    end
    chk("t1_ticks0", n0, 3);

    // Reprogram ch0 to H=1 mid-period.
    sync_clr = 1'b1;
    step();
    chk("t2_clr_clk",  32'(clk_out), 32'd0);
    chk("t2_clr_pend", 32'(pend),    32'd0);
    repeat (3) step();
    wr(4'd0, 32'd1);
    step();
    chk("t2_pend_set", 32'(pend[0]),    32'd1);
    chk("t2_clk_low",  32'(clk_out[0]), 32'd0);
    w = 0;
    while (!tick[0] && w < 6000) begin
      step();
      w++;
    end
    chk("t2_wait",     w, 4996);
    chk("t2_pend_clr", 32'(pend[0]),    32'd0);
    chk("t2_rise",     32'(clk_out[0]), 32'd1);
    run0(7, 32'b0011001, 32'b0001000, 32'd0, "t2_run");

    // Write exactly at the terminal cycle, then last-write-wins.
    wr(4'd0, 32'd3);
    run0(16, 32'hC3C3, 32'h4041, 32'h0003, "t3_col");
    wr(4'd0, 32'd5);
    run0(1, 32'd1, 32'd0, 32'd1, "t3_w5");
    wr(4'd0, 32'd2);
    run0(1, 32'd1, 32'd0, 32'd1, "t3_w2");
    run0(8, 32'h38, 32'h08, 32'd0, "t3_h2");

    // sync_clr during ch0 high phase with H=4.
    wr(4'd0, 32'd4);
    run0(1, 32'd0, 32'd0, 32'd1, "t4_w4");
    run0(1, 32'd1, 32'd1, 32'd0, "t4_apply");
    run0(2, 32'd3, 32'd0, 32'd0, "t4_hi");
    sync_clr = 1'b1;
    step();
    chk("t4_clr_clk",  32'(clk_out), 32'd0);
    chk("t4_clr_tick", 32'(tick),    32'd0);
    f0 = 0; f1 = 0;
    for (int k = 1; k <= 16; k++) begin
      step();
      if (tick[0] && f0 == 0) f0 = k;
      if (tick[1] && f1 == 0) f1 = k;
    end
    chk("t4_rise0", f0, 5);
    chk("t4_rise1", f1, 10);

    // Drop en[0] mid high phase for 7 cycles, then re-enable.
    en = 2'b10;
    for (int k = 0; k < 7; k++) begin
      step();
      chk($sformatf("t5_off_clk%0d", k),  32'(clk_out[0]), 32'd0);
      chk($sformatf("t5_off_tick%0d", k), 32'(tick[0]),    32'd0);
    end
    en = 2'b11;
    w = 0;
    while (!tick[0] && w < 20) begin
      step();
      w++;
    end
    chk("t5_reen", w, 5);
    wr(4'd0, 32'd0);
    run0(8, 32'hAF, 32'hA0, 32'h0F, "t5_h0");
    run0(4, 32'hA, 32'hA, 32'd0, "t5_alt");

    // Async reset between clocks with a pending ch1 write.
    wr(4'd1, 32'd2);
    step();
    chk("t6_pend1", 32'(pend), 32'd2);
    #3;
    rstn = 1'b0;
    #1;
    chk("t6_async_clk",  32'(clk_out), 32'd0);
    chk("t6_async_tick", 32'(tick),    32'd0);
    chk("t6_async_pend", 32'(pend),    32'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    wr(4'd5, 32'd0);
    f0 = 0; f1 = 0; s1 = 0;
    for (int k = 1; k <= 5001; k++) begin
      step();
      if (k == 1) chk("t6_badch", 32'(pend), 32'd0);
      if (tick[0] && f0 == 0) f0 = k;
      if (tick[1]) begin
        if (f1 == 0)      f1 = k;
        else if (s1 == 0) s1 = k;
      end
    end
    chk("t6_rise0",  f0, 5000);
    chk("t6_rise1",  f1, 10);
    chk("t6_rise1b", s1, 30);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
